stream_pattern_gen: RTL and testbench
=====================================

# stream_pattern_gen

Parametrised AXI-Stream test-pattern source that feeds the MAC TX streaming input (`in_0_*`) of the Ethernet wrapper in hardware bring-up builds. It generates packets of configurable length, with a configurable idle gap between packets, a configurable packet count and a selectable data pattern. It obeys the AXI-Stream valid/ready rules, so no beat is ever dropped or altered under backpressure.

## Interface
- `DATA_W`, 32, stream data width; even, ≥16
- `LEN_W`, 16, width of packet-length field (beats)
- `GAP_W`, 32, width of inter-packet gap field (cycles)
- `CNT_W`, 16, width of packet-count and sent-counter fields
- `clk`  in  1  sole clock; all logic on rising edge
- `glbl_rstn`  in  1  reset, synchronous, active-low
- `start`  in  1  single-cycle pulse; begins a run when idle
- `stop`  in  1  single-cycle pulse; ends the run at the next packet boundary
- `mode`  in  2  pattern: 0 counter, 1 LFSR, 2 constant, 3 sequence-tag
- `pkt_len`  in  LEN_W  beats per packet; 0 is treated as 1
- `gap_len`  in  GAP_W  idle cycles between packets; 0 means back-to-back
- `pkt_count`  in  CNT_W  packets per run; 0 means unlimited
- `seed`  in  DATA_W  initial counter/LFSR value; constant-mode word
- `out_valid`  out  1  stream valid
- `out_ready`  in  1  stream ready
- `out_data`  out  DATA_W  stream data
- `out_last`  out  1  high on the final beat of each packet
- `busy`  out  1  high whenever a run is active
- `done`  out  1  one-cycle pulse when a run ends
- `pkts_sent`  out  CNT_W  packets completed in the current/last run; wraps

## Operation
- States: IDLE, SEND, GAP.
- IDLE + `start`: latch `mode`, `pkt_len`, `gap_len`, `pkt_count`, `seed`. Clear `pkts_sent` and the beat counter, then go to SEND.
- Config inputs are ignored outside this latch. `start` while busy is ignored.
- SEND: `out_valid` is high. A beat transfers when `out_valid && out_ready`.
- `out_valid`, `out_data` and `out_last` never depend on `out_ready` combinationally and stay stable while stalled.
- `out_last` = (beat index == latched `pkt_len`−1).
- On a last-beat handshake, increment `pkts_sent`. The run ends if (`pkt_count`≠0 and `pkts_sent`+1 == `pkt_count`) or a stop is pending. Run end: go to IDLE and pulse `done`.
- Otherwise on a last-beat handshake: go to GAP if `gap_len`≠0; else stay in SEND with the next packet's first beat.
- GAP: `out_valid` low for exactly `gap_len` cycles, then SEND.
- `stop` sets a pending flag, cleared on entering IDLE. A packet is never truncated. A stop during GAP ends the run at the end of the gap, with no further packet. `stop` in IDLE is ignored.
- `start` and `stop` in the same IDLE cycle: start wins; the stop is discarded.
- Patterns (the word advances only on a handshake):
  - Counter: starts at `seed`, +1 per beat, wraps modulo 2^DATA_W, continuous across packets.
  - LFSR: Galois, advanced once per beat. A zero seed is replaced by 1.
  - Constant: `seed` on every beat.
  - Sequence-tag: upper DATA_W/2 = packet index mod 2^(DATA_W/2); lower DATA_W/2 = beat index within the packet.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `out_last` 0, `busy` 0, `done` 0, `pkts_sent` 0, state IDLE, stop flag 0.
- Reset mid-run: all of the above apply at the next edge. A beat in flight is abandoned.
- `start` sampled at edge N → `busy` and `out_valid` high from N+1. The first word is valid at N+1.
- Back-to-back packets (`gap_len`=0): `out_valid` stays high across the packet boundary, 1 beat/cycle sustained with `out_ready`=1.
- Gap: the last handshake at edge M gives `out_valid` low for M+1 … M+gap_len and high again at M+gap_len+1.
- Final handshake at edge M: `out_valid` and `busy` go low and `done` is high for cycle M+1 only.

## Configuration
- `SPG_LFSR_EN`: LFSR mode and its polynomial logic are compiled in.
- Without the macro, mode 1 behaves exactly as counter mode, and no LFSR logic is synthesised.

## Structure
- Package `spg_pkg`: state enum (IDLE/SEND/GAP), mode encodings, and the LFSR tap constant. DATA_W=32 uses taps x^32+x^22+x^2+x+1, with a function returning taps per width for 16/32/64.
- One sub-module, `spg_pattern`: holds the pattern register and next-word logic, advanced by an `adv` strobe and loaded by a `load` strobe. The FSM, counters and stream register stay in the top.

## Test plan
- Counter mode, `seed`=0x1C55, `pkt_len`=4, `gap_len`=0, `pkt_count`=2, ready=1 → 8 consecutive beats 0x1C55…0x1C5C; `out_last` on beats 4 and 8; `done` the cycle after beat 8; `pkts_sent`=2.
- Same run, `gap_len`=5 → exactly 5 valid-low cycles between beat 4 and beat 5.
- Random `out_ready` stalls (30%), sequence-tag mode, `pkt_len`=3, `pkt_count`=3 → received 0x0000_0000, 0x0000_0001, 0x0000_0002, 0x0001_0000, … 0x0002_0002; data and valid held through every stall.
- Unlimited run (`pkt_count`=0, `pkt_len`=10), `stop` pulsed on beat 3 of packet 5 → packet 5 completes all 10 beats; `done` follows; `pkts_sent`=5.
- LFSR mode with `seed`=0 (`SPG_LFSR_EN` defined) → first beat 0x00000001, second 0x80200003. Without the macro → 0x00000000, 0x00000001.
- `glbl_rstn` low for one cycle mid-packet → next cycle `out_valid`=0, `busy`=0, `pkts_sent`=0; a following `start` restarts from `seed`.

Source files
------------

// File: rtl/spg_pkg.sv
// spg_pkg: shared types and constants for stream_pattern_gen.
// Holds the FSM state encoding, the data-pattern mode encoding and the
// Galois LFSR tap masks used when SPG_LFSR_EN is defined.
package spg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } spg_state_e;

  typedef enum logic [1:0] {
    MODE_CNT   = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_CONST = 2'd2,
    MODE_SEQ   = 2'd3
  } spg_mode_e;

  // Right-shifting Galois mask for x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] SPG_LFSR_TAPS_32 = 32'h8020_0003;

  // Maximal-length right-shift Galois masks for the supported data widths.
  function automatic logic [63:0] spg_lfsr_taps(input int unsigned width);
    case (width)
      16:      return 64'h0000_0000_0000_B400;  // x^16+x^14+x^13+x^11+1
      64:      return 64'hD800_0000_0000_0000;  // x^64+x^63+x^61+x^60+1
      default: return {32'h0, SPG_LFSR_TAPS_32};
    endcase
  endfunction

endpackage

// File: rtl/stream_pattern_gen_if.sv
// stream_pattern_gen_if: AXI-Stream style valid/ready/data/last bundle.
// The master drives valid/data/last, the slave drives ready.
interface stream_pattern_gen_if #(
  parameter int DATA_W = 32
) ();

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/spg_pattern.sv
// spg_pattern: pattern register and next-word logic for stream_pattern_gen.
// The register always holds the word currently presented on the stream;
// load_i initialises it for a new run, adv_i steps it after a handshake.
// LFSR mode exists only when SPG_LFSR_EN is defined; otherwise mode 1
// counts exactly like counter mode.
module spg_pattern
  import spg_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              glbl_rstn,
  input  logic              load_i,
  input  logic              adv_i,
  input  logic              last_i,
  input  spg_mode_e         mode_i,
  input  logic [DATA_W-1:0] seed_i,
  output logic [DATA_W-1:0] word_o
);

  localparam int HALF = DATA_W / 2;

`ifdef SPG_LFSR_EN
  localparam logic [DATA_W-1:0] TAPS = DATA_W'(spg_lfsr_taps(DATA_W));
`endif

  spg_mode_e         mode_q, mode_d;
  logic [DATA_W-1:0] pat_q, pat_d;

  // Next pattern word: initial value on load, mode-specific step on advance.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    mode_d = mode_q;
    pat_d  = pat_q;
    if (load_i) begin
      mode_d = mode_i;
      case (mode_i)
        MODE_CNT:   pat_d = seed_i;
`ifdef SPG_LFSR_EN
        MODE_LFSR:  pat_d = (seed_i == '0) ? DATA_W'(1) : seed_i;
`else
        MODE_LFSR:  pat_d = seed_i;
`endif
        MODE_CONST: pat_d = seed_i;
        MODE_SEQ:   pat_d = '0;
      endcase
    end else if (adv_i) begin
      case (mode_q)
        MODE_CNT:   pat_d = pat_q + DATA_W'(1);
`ifdef SPG_LFSR_EN
        MODE_LFSR:  pat_d = (pat_q >> 1) ^ (pat_q[0] ? TAPS : '0);
`else
        MODE_LFSR:  pat_d = pat_q + DATA_W'(1);
`endif
        MODE_CONST: pat_d = pat_q;
        MODE_SEQ: begin
          // Upper half counts packets, lower half counts beats in the packet.
          if (last_i) pat_d = {pat_q[DATA_W-1:HALF] + HALF'(1), HALF'(0)};
          else        pat_d = {pat_q[DATA_W-1:HALF], pat_q[HALF-1:0] + HALF'(1)};
        end
      endcase
    end
  end

  // Pattern state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!glbl_rstn) begin
      mode_q <= MODE_CNT;
      pat_q  <= '0;
    end else begin
      mode_q <= mode_d;
      pat_q  <= pat_d;
    end
  end

  assign word_o = pat_q;

endmodule

// File: rtl/stream_pattern_gen.sv
// stream_pattern_gen: AXI-Stream test-pattern source.
// Sends pkt_count packets (0 = unlimited) of pkt_len beats separated by
// gap_len idle cycles. All stream outputs are registered and only move on
// a handshake, so backpressure never drops or alters a beat.
// Optional feature: define SPG_LFSR_EN to compile in the LFSR pattern.
module stream_pattern_gen
  import spg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16,
  parameter int GAP_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                glbl_rstn,
  input  logic                start,
  input  logic                stop,
  input  logic [1:0]          mode,
  input  logic [LEN_W-1:0]    pkt_len,
  input  logic [GAP_W-1:0]    gap_len,
  input  logic [CNT_W-1:0]    pkt_count,
  input  logic [DATA_W-1:0]   seed,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    pkts_sent,
  stream_pattern_gen_if.master axis
);

  spg_state_e        state_q;
  logic              valid_q, last_q, busy_q, done_q, stop_pend_q;
  logic [LEN_W-1:0]  beat_q, len_q;
  logic [GAP_W-1:0]  gap_q, gap_len_q;
  logic [CNT_W-1:0]  pkts_q, cnt_q;
  logic [DATA_W-1:0] word;

  logic             hs;
  logic             run_end;
  logic             load;
  logic [LEN_W-1:0] len_eff;

  assign len_eff = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
  assign hs      = valid_q & axis.out_ready;
  assign load    = (state_q == ST_IDLE) & start;
  // A stop arriving on the boundary cycle itself also ends the run there.
  assign run_end = ((cnt_q != '0) && (pkts_q + CNT_W'(1) == cnt_q))
                 || stop_pend_q || stop;

  spg_pattern #(.DATA_W(DATA_W)) u_pattern (
    .clk       (clk),
    .glbl_rstn (glbl_rstn),
    .load_i    (load),
    .adv_i     (hs),
    .last_i    (last_q),
    .mode_i    (spg_mode_e'(mode)),
    .seed_i    (seed),
    .word_o    (word)
  );

  // Run-control FSM with registered stream, status and counter outputs.
  always_ff @(posedge clk) begin
    if (!glbl_rstn) begin
      state_q     <= ST_IDLE;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      beat_q      <= '0;
      len_q       <= LEN_W'(1);
      gap_q       <= '0;
      gap_len_q   <= '0;
      pkts_q      <= '0;
      cnt_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads
      // the pre-edge value and a later assignment in the block wins.
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_SEND;
            valid_q     <= 1'b1;
            busy_q      <= 1'b1;
            len_q       <= len_eff;
            gap_len_q   <= gap_len;
            cnt_q       <= pkt_count;
            pkts_q      <= '0;
            beat_q      <= '0;
            last_q      <= (len_eff == LEN_W'(1));
            stop_pend_q <= 1'b0;
          end
        end

        ST_SEND: begin
          if (stop) stop_pend_q <= 1'b1;
          if (hs) begin
            if (last_q) begin
              pkts_q <= pkts_q + CNT_W'(1);
              beat_q <= '0;
              last_q <= (len_q == LEN_W'(1));
              if (run_end) begin
                state_q     <= ST_IDLE;
                valid_q     <= 1'b0;
                last_q      <= 1'b0;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
                stop_pend_q <= 1'b0;
              end else if (gap_len_q != '0) begin
                state_q <= ST_GAP;
                valid_q <= 1'b0;
                gap_q   <= gap_len_q;
              end
            end else begin
              beat_q <= beat_q + LEN_W'(1);
              last_q <= (beat_q + LEN_W'(1) == len_q - LEN_W'(1));
            end
          end
        end

        ST_GAP: begin
          if (stop) stop_pend_q <= 1'b1;
          if (gap_q == GAP_W'(1)) begin
            if (stop_pend_q || stop) begin
              state_q     <= ST_IDLE;
              last_q      <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              stop_pend_q <= 1'b0;
            end else begin
              state_q <= ST_SEND;
              valid_q <= 1'b1;
            end
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign axis.out_valid = valid_q;
  assign axis.out_data  = word;
  assign axis.out_last  = last_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pkts_sent      = pkts_q;

endmodule

// File: tb/tb_stream_pattern_gen.sv
// tb_stream_pattern_gen: directed self-checking bench for stream_pattern_gen.
// Expected values are hand-derived; SPG_LFSR_EN selects the LFSR expectations.
module tb_stream_pattern_gen;

  logic        clk = 1'b0;
  logic        glbl_rstn;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic [15:0] pkt_len;
  logic [31:0] gap_len;
  logic [15:0] pkt_count;
  logic [31:0] seed;
  logic        busy;
  logic        done;
  logic [15:0] pkts_sent;

  int checks = 0;
  int errors = 0;

  stream_pattern_gen_if #(.DATA_W(32)) axis ();

  stream_pattern_gen #(
    .DATA_W (32),
    .LEN_W  (16),
    .GAP_W  (32),
    .CNT_W  (16)
  ) dut (
    .clk       (clk),
    .glbl_rstn (glbl_rstn),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .pkt_len   (pkt_len),
    .gap_len   (gap_len),
    .pkt_count (pkt_count),
    .seed      (seed),
    .busy      (busy),
    .done      (done),
    .pkts_sent (pkts_sent),
    .axis      (axis)
  );

  always #5 clk = ~clk;

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Check one presented beat, then let it transfer (out_ready assumed high).
  task automatic expect_beat(input string tag, input logic [31:0] d, input logic l);
    check({tag, ".valid"}, 32'(axis.out_valid), 32'd1);
    check({tag, ".data"},  axis.out_data, d);
    check({tag, ".last"},  32'(axis.out_last), 32'(l));
    step();
  endtask

  // Check the cycle after the final handshake, then the done pulse clearing.
  task automatic expect_end(input string tag, input logic [15:0] pkts);
    check({tag, ".end_valid"}, 32'(axis.out_valid), 32'd0);
    check({tag, ".end_busy"},  32'(busy), 32'd0);
    check({tag, ".done"},      32'(done), 32'd1);
    check({tag, ".pkts_sent"}, 32'(pkts_sent), 32'(pkts));
    step();
    check({tag, ".done_clear"}, 32'(done), 32'd0);
  endtask

  // Pulse start with a config, then scramble the config inputs to show
  // they are only sampled at the start edge.
  task automatic start_run(input logic [1:0] m, input logic [15:0] len,
                           input logic [31:0] gap, input logic [15:0] cnt,
                           input logic [31:0] s);
    mode      = m;
    pkt_len   = len;
    gap_len   = gap;
    pkt_count = cnt;
    seed      = s;
    start     = 1'b1;
    step();
    start     = 1'b0;
    mode      = 2'(m + 2'd1);
    pkt_len   = len + 16'd3;
    gap_len   = gap + 32'd2;
    pkt_count = cnt + 16'd1;
    seed      = ~s;
  endtask

  initial begin
    int k;
    bit held;
    logic [31:0] held_data;
    logic [31:0] exp_d;

    glbl_rstn      = 1'b0;
    start          = 1'b0;
    stop           = 1'b0;
    mode           = 2'd0;
    pkt_len        = 16'd0;
    gap_len        = 32'd0;
    pkt_count      = 16'd0;
    seed           = 32'd0;
    axis.out_ready = 1'b1;
    step();
    step();

    // Reset state
    check("rst.valid", 32'(axis.out_valid), 32'd0);
    check("rst.data",  axis.out_data, 32'd0);
    check("rst.last",  32'(axis.out_last), 32'd0);
    check("rst.busy",  32'(busy), 32'd0);
    check("rst.done",  32'(done), 32'd0);
    check("rst.pkts",  32'(pkts_sent), 32'd0);
    glbl_rstn = 1'b1;
    step();

    // stop in IDLE has no effect
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("idle_stop.busy", 32'(busy), 32'd0);

    // Counter, back-to-back, two packets of four
    start_run(2'd0, 16'd4, 32'd0, 16'd2, 32'h0000_1C55);
    check("t1.busy", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) expect_beat("t1", 32'h1C55 + 32'(i), (i % 4) == 3);
    expect_end("t1", 16'd2);

    // Same run with a five-cycle gap
    start_run(2'd0, 16'd4, 32'd5, 16'd2, 32'h0000_1C55);
    for (int i = 0; i < 4; i++) expect_beat("t2", 32'h1C55 + 32'(i), i == 3);
    for (int g = 0; g < 5; g++) begin
      check("t2.gap_valid", 32'(axis.out_valid), 32'd0);
      check("t2.gap_busy",  32'(busy), 32'd1);
      step();
    end
    for (int i = 4; i < 8; i++) expect_beat("t2", 32'h1C55 + 32'(i), i == 7);
    expect_end("t2", 16'd2);

    // Sequence-tag with random 30% backpressure
    start_run(2'd3, 16'd3, 32'd0, 16'd3, 32'h1234_5678);
    k    = 0;
    held = 1'b0;
    held_data = '0;
    for (int cyc = 0; cyc < 300 && k < 9; cyc++) begin
      if (held) begin
        check("t3.stall_valid", 32'(axis.out_valid), 32'd1);
        check("t3.stall_data",  axis.out_data, held_data);
      end
      axis.out_ready = ($urandom_range(0, 99) >= 30);
      if (axis.out_valid && axis.out_ready) begin
        exp_d = {16'(k / 3), 16'(k % 3)};
        check("t3.data", axis.out_data, exp_d);
        check("t3.last", 32'(axis.out_last), 32'((k % 3) == 2));
        k++;
        held = 1'b0;
      end else if (axis.out_valid) begin
        held      = 1'b1;
        held_data = axis.out_data;
      end else begin
        held = 1'b0;
      end
      step();
    end
    check("t3.beats_seen", 32'(k), 32'd9);
    axis.out_ready = 1'b1;
    expect_end("t3", 16'd3);

    // Unlimited run stopped mid packet 5; a start while busy is ignored
    start_run(2'd0, 16'd10, 32'd0, 16'd0, 32'd0);
    for (int i = 0; i < 50; i++) begin
      if (i == 42) stop = 1'b1;
      if (i == 5) begin
        start = 1'b1;
        seed  = 32'hFFFF_0000;
      end
      expect_beat("t4", 32'(i), (i % 10) == 9);
      stop  = 1'b0;
      start = 1'b0;
    end
    expect_end("t4", 16'd5);

    // Constant pattern
    start_run(2'd2, 16'd3, 32'd0, 16'd1, 32'hA5A5_5A5A);
    for (int i = 0; i < 3; i++) expect_beat("t5", 32'hA5A5_5A5A, i == 2);
    expect_end("t5", 16'd1);

    // pkt_len of zero behaves as single-beat packets
    start_run(2'd0, 16'd0, 32'd0, 16'd2, 32'd7);
    expect_beat("t6", 32'd7, 1'b1);
    expect_beat("t6", 32'd8, 1'b1);
    expect_end("t6", 16'd2);

    // LFSR mode with a zero seed
    start_run(2'd1, 16'd2, 32'd0, 16'd1, 32'd0);
`ifdef SPG_LFSR_EN
    expect_beat("t7", 32'h0000_0001, 1'b0);
    expect_beat("t7", 32'h8020_0003, 1'b1);
`else
    expect_beat("t7", 32'h0000_0000, 1'b0);
    expect_beat("t7", 32'h0000_0001, 1'b1);
`endif
    expect_end("t7", 16'd1);

    // Reset in the middle of packet 2, then restart with start+stop together
    start_run(2'd0, 16'd4, 32'd0, 16'd0, 32'h0000_0100);
    for (int i = 0; i < 6; i++) expect_beat("t8", 32'h100 + 32'(i), (i % 4) == 3);
    check("t8.pkts_before", 32'(pkts_sent), 32'd1);
    glbl_rstn = 1'b0;
    step();
    glbl_rstn = 1'b1;
    check("t8.rst_valid", 32'(axis.out_valid), 32'd0);
    check("t8.rst_busy",  32'(busy), 32'd0);
    check("t8.rst_pkts",  32'(pkts_sent), 32'd0);
    check("t8.rst_data",  axis.out_data, 32'd0);
    stop = 1'b1;
    start_run(2'd0, 16'd2, 32'd0, 16'd0, 32'h0000_0100);
    stop = 1'b0;
    expect_beat("t8r", 32'h100, 1'b0);
    expect_beat("t8r", 32'h101, 1'b1);
    stop = 1'b1;
    expect_beat("t8r", 32'h102, 1'b0);
    stop = 1'b0;
    expect_beat("t8r", 32'h103, 1'b1);
    expect_end("t8r", 16'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
